// File: rtl/bcd_display_ctrl_pkg.sv
// Shared constants for the BCD display controller: FSM state encodings,
// operand and digit widths, seven-segment patterns and the blank code.
package bcd_display_ctrl_pkg;

    // FSM state encodings (one register bit is enough for two states)
    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;

    // Datapath geometry
    localparam int BIN_W      = 13;                     // binary operand width
    localparam int NUM_DIGITS = 4;                      // thousands..ones
    localparam int DIGIT_W    = 4;                      // bits per BCD digit
    localparam int BCD_W      = NUM_DIGITS * DIGIT_W;   // packed BCD width

    // Bit counter start value: 13 shift edges count 12 down to 0
    localparam logic [3:0] BIT_CNT_INIT = 4'(BIN_W - 1);

    // Any code above 9 decodes to all segments off; this one is used on purpose
    localparam logic [3:0] BLANK_CODE = 4'hF;

    // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Double-dabble correction: a digit of 5 or more would overflow past 9
    // after doubling, so bias it by 3 before the shift.
    function automatic logic [DIGIT_W-1:0] add3_if_ge5(input logic [DIGIT_W-1:0] d);
        return (d >= 4'd5) ? (d + 4'd3) : d;
    endfunction

endpackage

// File: rtl/bcd_display_ctrl_bcd_to_seg.sv
// Combinational BCD digit to active-low seven-segment decoder.
// Codes above 9 produce a fully blank digit.
module bcd_to_seg
    import bcd_display_ctrl_pkg::*;
(
    input  logic [DIGIT_W-1:0] i_digit,
    output logic [6:0]         o_seg
);

    // Pattern lookup for one digit
    always_comb begin
        o_seg = SEG_BLANK;
        case (i_digit)
            4'd0:    o_seg = SEG_0;
            4'd1:    o_seg = SEG_1;
            4'd2:    o_seg = SEG_2;
            4'd3:    o_seg = SEG_3;
            4'd4:    o_seg = SEG_4;
            4'd5:    o_seg = SEG_5;
            4'd6:    o_seg = SEG_6;
            4'd7:    o_seg = SEG_7;
            4'd8:    o_seg = SEG_8;
            4'd9:    o_seg = SEG_9;
            default: o_seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/bcd_display_ctrl.sv
// Binary-to-BCD converter (shift-and-add-3, one bit per clock) feeding a
// four-digit multiplexed seven-segment display. The converter and the
// display scan run independently; the display always shows the latched
// result, so a conversion in flight never disturbs the visible value.
module bcd_display_ctrl
    import bcd_display_ctrl_pkg::*;
#(
    parameter int REFRESH_DIV = 100000,   // cycles per digit, at least 2
    parameter int BLANK_LZ    = 1         // 1: blank leading zero digits
)(
    input  logic              clk,
    input  logic              rst,        // asynchronous, active low
    input  logic              start,
    input  logic [BIN_W-1:0]  num,
    output logic              busy,
    output logic              done,
    output logic [BCD_W-1:0]  bcd_out,
    output logic [3:0]        anode,
    output logic [6:0]        seg
);

    localparam int REF_W = $clog2(REFRESH_DIV);
    localparam logic [REF_W-1:0] REF_LAST = REF_W'(REFRESH_DIV - 1);

    // ------------------------------------------------------------------
    // Converter state
    // ------------------------------------------------------------------
    logic [0:0]             r_state;
    logic [BIN_W-1:0]       r_operand;
    logic [BCD_W-1:0]       r_scratch;
    logic [3:0]             r_bitcnt;
    logic                   r_done;
    logic [BCD_W-1:0]       r_bcd_out;

    // Display scan state
    logic [REF_W-1:0]       r_refresh;
    logic [1:0]             r_index;

    // Converter datapath
    logic [BCD_W-1:0]       w_adj;
    logic [BCD_W+BIN_W-1:0] w_shift_all;
    logic [BCD_W-1:0]       w_scratch_next;
    logic [BIN_W-1:0]       w_operand_next;

    // Display datapath
    logic [DIGIT_W-1:0]     w_digits [NUM_DIGITS];
    logic [NUM_DIGITS-1:0]  w_zero;
    logic [NUM_DIGITS-1:0]  w_lz;
    logic [DIGIT_W-1:0]     w_digit_sel;
    logic                   w_blank;
    logic [DIGIT_W-1:0]     w_seg_code;
    logic [6:0]             w_seg;

    // Per-digit add-3 correction applied before every shift
    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_adj
            assign w_adj[gi*DIGIT_W +: DIGIT_W] = add3_if_ge5(r_scratch[gi*DIGIT_W +: DIGIT_W]);
        end
    endgenerate

    // Shift the corrected scratch and the operand together; the operand
    // MSB falls into the scratch LSB and the operand refills with zero.
    assign w_shift_all    = {w_adj, r_operand} << 1;
    assign w_scratch_next = w_shift_all[BCD_W+BIN_W-1:BIN_W];
    assign w_operand_next = w_shift_all[BIN_W-1:0];

    // Conversion FSM: IDLE waits for start, SHIFT runs 13 edges then publishes
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= ST_IDLE;
            r_operand <= '0;
            r_scratch <= '0;
            r_bitcnt  <= '0;
            r_done    <= 1'b0;
            r_bcd_out <= '0;
        end else begin
            r_done <= 1'b0;
            if (r_state == ST_IDLE) begin
                if (start) begin
                    r_operand <= num;
                    r_scratch <= '0;
                    r_bitcnt  <= BIT_CNT_INIT;
                    r_state   <= ST_SHIFT;
                end
            end else begin
                r_scratch <= w_scratch_next;
                r_operand <= w_operand_next;
                r_bitcnt  <= r_bitcnt - 4'd1;
                if (r_bitcnt == 4'd0) begin
                    r_bcd_out <= w_scratch_next;
                    r_done    <= 1'b1;
                    r_state   <= ST_IDLE;
                end
            end
        end
    end

    assign busy    = (r_state == ST_SHIFT);
    assign done    = r_done;
    assign bcd_out = r_bcd_out;

    // Display scan: hold each digit REFRESH_DIV cycles, then move to the next
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_refresh <= '0;
            r_index   <= 2'd0;
        end else if (r_refresh == REF_LAST) begin
            r_refresh <= '0;
            r_index   <= r_index + 2'd1;
        end else begin
            r_refresh <= r_refresh + 1'b1;
        end
    end

    // Unpack digits and flag the ones that are zero together with every
    // digit above them (leading zeros).
    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            assign w_digits[gi] = r_bcd_out[gi*DIGIT_W +: DIGIT_W];
            assign w_zero[gi]   = (w_digits[gi] == '0);
            assign w_lz[gi]     = &w_zero[NUM_DIGITS-1:gi];
        end
    endgenerate

    // Choose the scanned digit, replacing leading zeros by the blank code;
    // the ones digit is always shown so a zero result still reads "0".
    always_comb begin
        w_digit_sel = w_digits[r_index];
        w_blank     = (BLANK_LZ != 0) && (r_index != 2'd0) && w_lz[r_index];
        w_seg_code  = w_blank ? BLANK_CODE : w_digit_sel;
    end

    bcd_to_seg u_bcd_to_seg (
        .i_digit (w_seg_code),
        .o_seg   (w_seg)
    );

    assign seg   = w_seg;
    assign anode = ~(4'b0001 << r_index);

endmodule

// File: tb/tb_bcd_display_ctrl.sv
// Self-checking bench for bcd_display_ctrl: a transaction-level model
// (decimal arithmetic plus a cycle count since reset) is compared with the
// DUT outputs every cycle, alongside directed literal checks.
module tb_bcd_display_ctrl;

    localparam int RDIV = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [12:0] num;
    logic        busy;
    logic        done;
    logic [15:0] bcd_out;
    logic [3:0]  anode;
    logic [6:0]  seg;

    int n_checks = 0;
    int n_fail   = 0;

    bcd_display_ctrl #(.REFRESH_DIV(RDIV), .BLANK_LZ(1)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .num     (num),
        .busy    (busy),
        .done    (done),
        .bcd_out (bcd_out),
        .anode   (anode),
        .seg     (seg)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
            4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
            8: return 7'h00;  9: return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    function automatic logic [15:0] to_bcd(input int v);
        return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    function automatic int pow10(input int k);
        int p = 1;
        for (int i = 0; i < k; i++) p = p * 10;
        return p;
    endfunction

    // ---------------- behavioural model ----------------
    bit m_busy, m_done;
    int m_k, m_val, m_pending, m_edges;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_busy <= 0; m_done <= 0; m_k <= 0; m_val <= 0; m_pending <= 0; m_edges <= 0;
        end else begin
            m_edges <= m_edges + 1;
            m_done  <= 0;
            if (m_busy) begin
                if (m_k == 12) begin
                    m_val  <= m_pending;
                    m_done <= 1;
                    m_busy <= 0;
                end else begin
                    m_k <= m_k + 1;
                end
            end else if (start) begin
                m_pending <= int'(num);
                m_busy    <= 1;
                m_k       <= 0;
            end
        end
    end

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        int idx, p, d;
        logic [6:0] es;
        logic [3:0] ea;
        idx = (m_edges / RDIV) % 4;
        p   = pow10(idx);
        d   = (m_val / p) % 10;
        es  = (idx != 0 && m_val < p) ? 7'h7F : seg_of(d);
        ea  = 4'b1111 ^ 4'(1 << idx);
        check("busy", 32'(busy), 32'(m_busy));
        check("done", 32'(done), 32'(m_done));
        check("bcd_out", 32'(bcd_out), 32'(to_bcd(m_val)));
        check("anode", 32'(anode), 32'(ea));
        check("seg", 32'(seg), 32'(es));
    end

    // ---------------- stimulus helpers ----------------
    task automatic start_conv(input int v);
        @(negedge clk);
        start = 1'b1;
        num   = 13'(v);
        @(negedge clk);
        start = 1'b0;
    endtask

    // Waits for done at negedges; optionally jitters inputs or re-pulses start
    task automatic wait_done(input bit noise, input int pulse_at, output int bc);
        bit ok = 0;
        bc = 0;
        for (int i = 0; i < 40; i++) begin
            if (done) begin ok = 1; break; end
            if (busy) bc++;
            start = 1'b0;
            if (noise) begin
                start = 1'($urandom_range(0, 1));
                num   = 13'($urandom_range(0, 8191));
            end
            if (i == pulse_at) begin
                start = 1'b1;
                num   = 13'd5;
            end
            @(negedge clk);
        end
        start = 1'b0;
        check("done_seen", 32'(ok), 32'd1);
    endtask

    logic [3:0] an_lit [4];
    logic [6:0] seg1234 [4];

    initial begin
        int bc, ndone, i0, prev_cyc, cyc;
        logic [3:0] prev_an;
        bit changed;

        an_lit[0] = 4'b1110; an_lit[1] = 4'b1101; an_lit[2] = 4'b1011; an_lit[3] = 4'b0111;
        seg1234[0] = 7'h19; seg1234[1] = 7'h30; seg1234[2] = 7'h24; seg1234[3] = 7'h79;

        rst = 1'b0; start = 1'b0; num = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_bcd", 32'(bcd_out), 32'h0);
        check("rst_anode", 32'(anode), 32'b1110);
        check("rst_seg", 32'(seg), 32'h40);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // 1234: latency, busy length, result
        start_conv(1234);
        wait_done(0, -1, bc);
        check("busy_cycles_1234", 32'(bc), 32'd13);
        check("lit_1234", 32'(bcd_out), 32'h1234);
        $display("conv 1234 -> %h busy=%0d", bcd_out, bc);

        // Scan sequence with 4-cycle hold
        changed = 0;
        for (int i = 0; i < 8; i++) begin
            prev_an = anode;
            @(negedge clk);
            if (anode != prev_an) begin changed = 1; break; end
        end
        check("scan_advances", 32'(changed), 32'd1);
        i0 = -1;
        for (int k = 0; k < 4; k++) if (anode == an_lit[k]) i0 = k;
        check("scan_onehot", 32'(i0 >= 0), 32'd1);
        if (i0 >= 0) begin
            for (int j = 0; j < 16; j++) begin
                check("scan_anode", 32'(anode), 32'(an_lit[(i0 + j / 4) % 4]));
                check("scan_seg", 32'(seg), 32'(seg1234[(i0 + j / 4) % 4]));
                @(negedge clk);
            end
        end
        $display("scan check on 1234 complete");

        // 8191 and 0
        start_conv(8191);
        wait_done(0, -1, bc);
        check("lit_8191", 32'(bcd_out), 32'h8191);
        $display("conv 8191 -> %h", bcd_out);
        start_conv(0);
        wait_done(0, -1, bc);
        check("lit_0", 32'(bcd_out), 32'h0);
        for (int j = 0; j < 16; j++) begin
            @(negedge clk);
            check("zero_blank", 32'(seg), (anode == 4'b1110) ? 32'h40 : 32'h7F);
        end
        $display("conv 0 -> %h blank check done", bcd_out);

        // Start re-pulsed mid-conversion is ignored
        start_conv(1234);
        wait_done(0, 5, bc);
        check("ignore_start", 32'(bcd_out), 32'h1234);
        ndone = 0;
        for (int j = 0; j < 20; j++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("single_done", 32'(ndone), 32'd0);
        $display("re-pulse ignored -> %h", bcd_out);

        // Reset mid-conversion
        start_conv(999);
        repeat (5) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_done", 32'(done), 32'd0);
        check("arst_bcd", 32'(bcd_out), 32'h0);
        check("arst_anode", 32'(anode), 32'b1110);
        check("arst_seg", 32'(seg), 32'h40);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        ndone = 0;
        for (int j = 0; j < 20; j++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("no_done_after_rst", 32'(ndone), 32'd0);
        start_conv(42);
        wait_done(0, -1, bc);
        check("lit_42", 32'(bcd_out), 32'h0042);
        $display("reset abort then conv 42 -> %h", bcd_out);

        // start held high: back-to-back conversions
        @(negedge clk);
        start = 1'b1;
        prev_cyc = -1;
        for (cyc = 0; cyc < 75; cyc++) begin
            num = 13'($urandom_range(0, 8191));
            @(negedge clk);
            if (done) begin
                if (prev_cyc >= 0) check("b2b_period", 32'(cyc - prev_cyc), 32'd14);
                $display("b2b done at cycle %0d bcd=%h", cyc, bcd_out);
                prev_cyc = cyc;
            end
        end
        start = 1'b0;
        repeat (20) @(negedge clk);

        // Random conversions with input noise during busy
        for (int t = 0; t < 40; t++) begin
            int v, gap;
            v   = $urandom_range(0, 8191);
            gap = $urandom_range(0, 3);
            repeat (gap) begin
                num = 13'($urandom_range(0, 8191));
                @(negedge clk);
            end
            start_conv(v);
            wait_done(1, -1, bc);
            check("rand_lit", 32'(bcd_out), 32'(to_bcd(v)));
            $display("rand conv %0d -> %h", v, bcd_out);
        end

        repeat (5) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
